// File: rtl/mux_set.sv
// Bank of M registered N:1 word multiplexers sharing one input vector.
// Optional macro MUX_SET_SEL_ERR_EN adds a registered per-mux out-of-range flag (sel_err).
module mux_set #(
  parameter int width = 8,
  parameter int N     = 1,
  parameter int M     = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [width-1:0]          in  [N-1:0],
  input  logic [$clog2(N)-(N!=1):0] sel [M-1:0],
  output logic [width-1:0]          out [M-1:0],
  output logic                      out_valid
`ifdef MUX_SET_SEL_ERR_EN
  ,
  output logic [M-1:0]              sel_err
`endif
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic out_valid_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= en;
    end
  end

  assign out_valid = out_valid_reg;

  for (genvar gi = 0; gi < M; gi++) begin : g_mux
    logic [width-1:0] word_next;
    logic [width-1:0] word_reg;
`ifdef MUX_SET_SEL_ERR_EN
    logic             oor_next;
    logic             err_reg;
`endif

    if (N == 1) begin : g_single
      // A single input is routed regardless of the select bit.
      logic unused_sel;
      assign unused_sel = ^sel[gi];
      assign word_next  = in[0];
`ifdef MUX_SET_SEL_ERR_EN
      assign oor_next   = 1'b0;
`endif
    end else begin : g_multi
      // Compare against each legal index so an out-of-range select never reads past in[N-1].
      always_comb begin
        word_next = '0;
`ifdef MUX_SET_SEL_ERR_EN
        oor_next  = 1'b1;
`endif
        for (int j = 0; j < N; j++) begin
          if (sel[gi] == SW'(j)) begin
            word_next = in[j];
`ifdef MUX_SET_SEL_ERR_EN
            oor_next  = 1'b0;
`endif
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        word_reg <= '0;
      end else if (en) begin
        word_reg <= word_next;
      end
    end

    assign out[gi] = word_reg;

`ifdef MUX_SET_SEL_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        err_reg <= 1'b0;
      end else if (en) begin
        err_reg <= oor_next;
      end
    end

    assign sel_err[gi] = err_reg;
`endif
  end

endmodule

// File: tb/tb_mux_set.sv
// Randomized bench for mux_set: three configurations (N=1/M=1, N=4/M=3, N=3/M=2)
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_mux_set;
  logic clk;
  logic reset_n;
  logic en;

  logic [7:0] in_a  [0:0];
  logic       sel_a [0:0];
  logic [7:0] out_a [0:0];
  logic       out_valid_a;

  logic [7:0] in_b  [3:0];
  logic [1:0] sel_b [2:0];
  logic [7:0] out_b [2:0];
  logic       out_valid_b;

  logic [7:0] in_c  [2:0];
  logic [1:0] sel_c [1:0];
  logic [7:0] out_c [1:0];
  logic       out_valid_c;

`ifdef MUX_SET_SEL_ERR_EN
  logic [0:0] sel_err_a;
  logic [2:0] sel_err_b;
  logic [1:0] sel_err_c;
`endif

  mux_set #(.width(8), .N(1), .M(1)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in_a), .sel(sel_a),
    .out(out_a), .out_valid(out_valid_a)
`ifdef MUX_SET_SEL_ERR_EN
    , .sel_err(sel_err_a)
`endif
  );

  mux_set #(.width(8), .N(4), .M(3)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in_b), .sel(sel_b),
    .out(out_b), .out_valid(out_valid_b)
`ifdef MUX_SET_SEL_ERR_EN
    , .sel_err(sel_err_b)
`endif
  );

  mux_set #(.width(8), .N(3), .M(2)) u_c (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in_c), .sel(sel_c),
    .out(out_c), .out_valid(out_valid_c)
`ifdef MUX_SET_SEL_ERR_EN
    , .sel_err(sel_err_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each output is the selected word of the last enabled capture.
  logic [7:0] exp_a [0:0];
  logic [7:0] exp_b [2:0];
  logic [7:0] exp_c [1:0];
  logic [1:0] exp_err_c;
  logic       exp_v;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_a[0]  <= 8'h00;
      for (int k = 0; k < 3; k++) exp_b[k] <= 8'h00;
      for (int k = 0; k < 2; k++) exp_c[k] <= 8'h00;
      exp_err_c <= 2'b00;
      exp_v     <= 1'b0;
    end else if (en) begin
      exp_a[0] <= in_a[0];
      for (int k = 0; k < 3; k++) exp_b[k] <= in_b[sel_b[k]];
      for (int k = 0; k < 2; k++) begin
        exp_c[k]     <= (int'(sel_c[k]) < 3) ? in_c[sel_c[k]] : 8'h00;
        exp_err_c[k] <= (int'(sel_c[k]) >= 3);
      end
      exp_v <= 1'b1;
    end else begin
      exp_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid_a", 32'(out_valid_a), 32'(exp_v));
      check("valid_b", 32'(out_valid_b), 32'(exp_v));
      check("valid_c", 32'(out_valid_c), 32'(exp_v));
      check("out_a[0]", 32'(out_a[0]), 32'(exp_a[0]));
      for (int k = 0; k < 3; k++) check($sformatf("out_b[%0d]", k), 32'(out_b[k]), 32'(exp_b[k]));
      for (int k = 0; k < 2; k++) check($sformatf("out_c[%0d]", k), 32'(out_c[k]), 32'(exp_c[k]));
`ifdef MUX_SET_SEL_ERR_EN
      check("sel_err_a", 32'(sel_err_a), 32'd0);
      check("sel_err_b", 32'(sel_err_b), 32'd0);
      check("sel_err_c", 32'(sel_err_c), 32'(exp_err_c));
`endif
    end
  end

  // Wait for the next capture edge and land one time unit after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1;
    en      = 1'b0;
    in_a[0] = 8'h00; sel_a[0] = 1'b0;
    for (int i = 0; i < 4; i++) in_b[i] = 8'h00;
    for (int i = 0; i < 3; i++) sel_b[i] = 2'd0;
    for (int i = 0; i < 3; i++) in_c[i] = 8'h00;
    for (int i = 0; i < 2; i++) sel_c[i] = 2'd0;
    #1 reset_n = 1'b0;
    step();
    check("rst out_a", 32'(out_a[0]), 32'h00);
    check("rst out_b2", 32'(out_b[2]), 32'h00);
    check("rst valid_c", 32'(out_valid_c), 32'h0);
    chk_on  = 1'b1;
    reset_n = 1'b1;
    step();

    // Mixed selects: N=1 with sel=1, permuted selects, and an out-of-range select.
    en = 1'b1;
    in_a[0] = 8'haa; sel_a[0] = 1'b1;
    for (int i = 0; i < 4; i++) in_b[i] = 8'(i + 1);
    sel_b[0] = 2'd2; sel_b[1] = 2'd0; sel_b[2] = 2'd3;
    in_c[0] = 8'h11; in_c[1] = 8'h22; in_c[2] = 8'h33;
    sel_c[0] = 2'd3; sel_c[1] = 2'd2;
    step();
    check("lit out_a sel1", 32'(out_a[0]), 32'haa);
    check("lit valid_a", 32'(out_valid_a), 32'h1);
    check("lit out_b0", 32'(out_b[0]), 32'h3);
    check("lit out_b1", 32'(out_b[1]), 32'h1);
    check("lit out_b2", 32'(out_b[2]), 32'h4);
    check("lit out_c0 oor", 32'(out_c[0]), 32'h00);
    check("lit out_c1", 32'(out_c[1]), 32'h33);
`ifdef MUX_SET_SEL_ERR_EN
    check("lit sel_err_c", 32'(sel_err_c), 32'h1);
`endif

    // Broadcast: every mux of u_b picks input 1.
    sel_a[0] = 1'b0;
    for (int i = 0; i < 3; i++) sel_b[i] = 2'd1;
    step();
    check("lit out_a sel0", 32'(out_a[0]), 32'haa);
    for (int k = 0; k < 3; k++) check($sformatf("lit bcast out_b%0d", k), 32'(out_b[k]), 32'h2);

    // Hold: en low with new inputs must not disturb outputs.
    en = 1'b0;
    in_a[0] = 8'h55;
    for (int i = 0; i < 4; i++) in_b[i] = 8'h99;
    step();
    check("lit hold out_b0", 32'(out_b[0]), 32'h2);
    check("lit hold out_a", 32'(out_a[0]), 32'haa);
    check("lit hold valid_b", 32'(out_valid_b), 32'h0);

    // Asynchronous reset between edges clears outputs without a clock edge.
    reset_n = 1'b0;
    #1;
    check("async rst out_a", 32'(out_a[0]), 32'h00);
    check("async rst out_b1", 32'(out_b[1]), 32'h00);
    check("async rst out_c1", 32'(out_c[1]), 32'h00);
    @(negedge clk);
    #1 reset_n = 1'b1;
    step();
    check("post rst out_b0", 32'(out_b[0]), 32'h00);
    check("post rst valid_a", 32'(out_valid_a), 32'h0);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int cyc = 0; cyc < 400; cyc++) begin
      en = ($urandom_range(0, 3) != 0);
      in_a[0]  = 8'($urandom);
      sel_a[0] = 1'($urandom);
      for (int i = 0; i < 4; i++) in_b[i] = 8'($urandom);
      for (int i = 0; i < 3; i++) sel_b[i] = 2'($urandom);
      for (int i = 0; i < 3; i++) in_c[i] = 8'($urandom);
      for (int i = 0; i < 2; i++) sel_c[i] = 2'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        #1;
        check("rnd rst out_c0", 32'(out_c[0]), 32'h00);
        reset_n = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
